gamepad_pmod_transmitter: RTL and testbench
===========================================

GAMEPAD_PMOD_TRANSMITTER -- requirements
Module: gamepad_pmod_transmitter

Interface
REQ-001 Parameter BIT_WIDTH, default 12, SHALL set the number of button bits serialized per frame.
REQ-002 Parameter CLK_DIV, default 4, SHALL set the system clocks per pmod_clk half-period; legal range >= 2.
REQ-003 clk  input  1  system clock; the block SHALL use this single clock domain only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 buttons  input  BIT_WIDTH  parallel button word; for BIT_WIDTH=12 the bit order SHALL be {b,y,select,start,up,down,left,right,a,x,l,r} from MSB to LSB, with 1 meaning pressed.
REQ-006 send_req  input  1  frame request, sampled only in IDLE.
REQ-007 busy  output  1  frame in progress.
REQ-008 done  output  1  one-cycle pulse at frame completion.
REQ-009 pmod_data  output  1  serial data line.
REQ-010 pmod_clk  output  1  serial clock line.
REQ-011 pmod_latch  output  1  frame latch line.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH and GAP; each non-IDLE state SHALL last exactly CLK_DIV cycles, timed by a divider counter.
REQ-013 IDLE with send_req=1 at a clock edge SHALL capture buttons into a shift register, enter SHIFT_LO and set busy=1 on the next cycle.
REQ-014 SHIFT_LO SHALL drive pmod_clk=0 and pmod_data=the current bit, MSB first; the data bit SHALL change only on entry to SHIFT_LO.
REQ-015 SHIFT_HI SHALL drive pmod_clk=1 with pmod_data held unchanged, giving the receiver a rising-edge sample with CLK_DIV cycles of setup and hold.
REQ-016 After the SHIFT_HI of bit 0 the FSM SHALL enter LATCH; otherwise it SHALL return to SHIFT_LO with the bit index decremented.
REQ-017 LATCH SHALL drive pmod_latch=1, pmod_clk=0 and pmod_data=0; GAP SHALL drive all three lines low.
REQ-018 Each frame SHALL produce exactly BIT_WIDTH rising edges of pmod_clk and one latch pulse, and SHALL last (2*BIT_WIDTH+2)*CLK_DIV cycles from busy rising to IDLE (104 cycles at the defaults).
REQ-019 On the first IDLE cycle after GAP, the block SHALL drive done=1 and busy=0.
REQ-020 A send_req=1 in that same cycle SHALL start the next frame, so a held send_req gives back-to-back frames separated only by GAP plus one IDLE cycle.
REQ-021 Changes on buttons while busy=1 SHALL NOT affect the frame in flight.
REQ-022 send_req while busy=1 SHALL be ignored, not queued.
REQ-023 buttons SHALL be transmitted unmodified, including all-ones, which the receiver decodes as "not present".
REQ-024 The bit counter SHALL be clog2(BIT_WIDTH) bits wide and the divider clog2(CLK_DIV) bits wide; neither counter SHALL wrap within a state.

Reset
REQ-025 While reset=1 at a clock edge, the next-cycle values SHALL be: state=IDLE, busy=0, done=0, pmod_data=0, pmod_clk=0, pmod_latch=0, shift register=0, counters=0.
REQ-026 Reset mid-frame SHALL abort without a latch pulse, so the receiver's data register is not updated by a partial frame.
REQ-027 send_req asserted during reset SHALL be ignored.

Structure
REQ-028 A shared gamepad pmod package SHALL hold the FSM state encoding, the default BIT_WIDTH (12), the default CLK_DIV and the button bit-index constants shared with the receiver and decoder.
REQ-029 The block SHALL be a single module with no sub-module; the divider and bit counter SHALL remain inline.

Verification
REQ-030 Reset, then idle 20 cycles -> all outputs 0; no pmod_clk edges.
REQ-031 buttons=12'hA5C with one send_req pulse, looped back into gamepad_pmod_single -> 12 rising pmod_clk edges with sampled data 1,0,1,0,0,1,0,1,1,1,0,0; 4-cycle latch pulse; done 104 cycles after busy rises; decoder outputs b=1, select=1, down=1, right=1, a=1, x=1, all others 0, is_present=1.
REQ-032 Change buttons from 12'hA5C to 12'h000 at bit 6 -> the received word is still 12'hA5C.
REQ-033 Hold send_req=1 for 3 frames with buttons=12'h001, then 12'h800 -> three complete frames, done pulsing 3 times with period 105 cycles, and each received word matching buttons as captured at that frame's start.
REQ-034 Assert reset for 1 cycle at bit 5 -> outputs 0 next cycle, no latch pulse, receiver word unchanged; a following frame with 12'h0F0 is received correctly.
REQ-035 buttons=12'hFFF -> received is_present=0; buttons=12'h000 -> is_present=1 with all buttons 0.

Source files
------------

// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the gamepad pmod link: FSM state encoding,
// default frame geometry and the button bit positions used by the
// transmitter, receiver and decoder.
package gamepad_pmod_pkg;

  localparam int DEFAULT_BIT_WIDTH = 12;
  localparam int DEFAULT_CLK_DIV   = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_LATCH    = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // Button positions in the 12-bit word, MSB first on the wire
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

endpackage

// File: rtl/gamepad_pmod_transmitter.sv
// Serializes a parallel button word onto the pmod data/clock/latch lines.
// Each frame: BIT_WIDTH low/high clock phases (data MSB first, stable across
// the rising edge), one latch phase, one gap phase; every phase lasts
// CLK_DIV system clocks. All pmod lines are registered.
module gamepad_pmod_transmitter
  import gamepad_pmod_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] buttons,
  input  logic                 send_req,
  output logic                 busy,
  output logic                 done,
  output logic                 pmod_data,
  output logic                 pmod_clk,
  output logic                 pmod_latch
);

  localparam int BIT_CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]           state;
  logic [BIT_WIDTH-1:0] shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0]     div;
  logic                 div_last;

  // Final cycle of the current phase
  always_comb begin
    div_last = (div == DIV_W'(CLK_DIV - 1));
  end

  // Frame FSM with inline phase divider and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pmod_data  <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE) begin
        div <= div_last ? '0 : div + DIV_W'(1);
      end
      case (state)
        ST_IDLE: begin
          div <= '0;
          if (send_req) begin
            // MSB goes straight to the line; shreg keeps the whole word so
            // the next bit is always found at its top after each shift.
            shreg      <= buttons;
            pmod_data  <= buttons[BIT_WIDTH-1];
            pmod_clk   <= 1'b0;
            pmod_latch <= 1'b0;
            bit_cnt    <= BIT_CNT_W'(BIT_WIDTH - 1);
            busy       <= 1'b1;
            state      <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (div_last) begin
            // Advance the shifter now; pmod_data stays held through the high phase
            shreg    <= shreg << 1;
            pmod_clk <= 1'b1;
            state    <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (div_last) begin
            pmod_clk <= 1'b0;
            if (bit_cnt == '0) begin
              pmod_data  <= 1'b0;
              pmod_latch <= 1'b1;
              state      <= ST_LATCH;
            end else begin
              pmod_data <= shreg[BIT_WIDTH-1];
              bit_cnt   <= bit_cnt - BIT_CNT_W'(1);
              state     <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (div_last) begin
            pmod_latch <= 1'b0;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (div_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy       <= 1'b0;
          pmod_data  <= 1'b0;
          pmod_clk   <= 1'b0;
          pmod_latch <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// Testbench for gamepad_pmod_transmitter: a receiver model on the pmod lines
// feeds a scoreboard that is checked on every done pulse.
module tb_gamepad_pmod_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] buttons;
  logic        send_req;
  logic        busy, done, pmod_data, pmod_clk, pmod_latch;

  gamepad_pmod_transmitter #(.BIT_WIDTH(12), .CLK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .send_req   (send_req),
    .busy       (busy),
    .done       (done),
    .pmod_data  (pmod_data),
    .pmod_clk   (pmod_clk),
    .pmod_latch (pmod_latch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] word;
    logic        present;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;

  // receiver model state
  logic [11:0] rx_sh   = '0;
  logic [11:0] rx_word = '0;
  logic        prev_clk   = 1'b0;
  logic        prev_latch = 1'b0;
  int          edge_cnt = 0, latch_len = 0, busy_len = 0;
  int          latch_pulses = 0, done_cnt = 0, cyc = 0;
  int          done_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: receiver model plus scoreboard pop on each done pulse
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1) begin
        edge_cnt  = 0;
        latch_len = 0;
        busy_len  = 0;
      end else begin
        if (pmod_clk === 1'b1 && prev_clk === 1'b0) begin
          rx_sh = {rx_sh[10:0], pmod_data};
          edge_cnt++;
        end
        if (pmod_latch === 1'b1) begin
          latch_len++;
          if (prev_latch === 1'b0) begin
            rx_word = rx_sh;
            latch_pulses++;
          end
        end
        if (busy === 1'b1) busy_len++;
        if (done === 1'b1) begin
          done_cnt++;
          done_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rx_word", {20'd0, rx_word}, {20'd0, e.word});
            check("is_present", {31'd0, rx_word != 12'hFFF}, {31'd0, e.present});
            check("clk_edges", edge_cnt, 32'd12);
            check("latch_len", latch_len, 32'd4);
            check("busy_cycles", busy_len, 32'd104);
          end
          edge_cnt  = 0;
          latch_len = 0;
          busy_len  = 0;
        end
      end
      prev_clk   = pmod_clk;
      prev_latch = pmod_latch;
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_edges(input int target, input int budget, input string name);
    int n = 0;
    while (edge_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, (edge_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic start_frame(input logic [11:0] word);
    @(posedge clk);
    #1;
    buttons  = word;
    send_req = 1'b1;
    @(posedge clk);
    #1;
    send_req = 1'b0;
  endtask

  initial begin
    int          base;
    logic [11:0] saved_word;
    int          saved_latches;

    reset    = 1'b1;
    send_req = 1'b1;
    buttons  = 12'hA5C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, pmod_data, pmod_clk, pmod_latch}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    send_req = 1'b0;

    // idle: send_req held during reset must not have started a frame
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {27'd0, busy, done, pmod_data, pmod_clk, pmod_latch}, 32'd0);
    end
    check("idle_edges", edge_cnt, 32'd0);

    // single frame 12'hA5C with start latency checks
    exp_q.push_back('{word: 12'hA5C, present: 1'b1});
    base = done_cnt;
    @(posedge clk);
    #1;
    send_req = 1'b1;
    @(negedge clk);
    check("busy_before_capture", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    send_req = 1'b0;
    @(negedge clk);
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("first_bit", {31'd0, pmod_data}, 32'd1);
    check("clk_low_first", {31'd0, pmod_clk}, 32'd0);
    wait_done(base + 1, 200, "done_a5c");

    // buttons change mid-frame do not affect the frame in flight
    exp_q.push_back('{word: 12'hA5C, present: 1'b1});
    base = done_cnt;
    start_frame(12'hA5C);
    wait_edges(6, 100, "reach_bit6");
    buttons = 12'h000;
    wait_done(base + 1, 200, "done_midchange");

    // held send_req: three back-to-back frames, 001 then 800 twice
    exp_q.push_back('{word: 12'h001, present: 1'b1});
    exp_q.push_back('{word: 12'h800, present: 1'b1});
    exp_q.push_back('{word: 12'h800, present: 1'b1});
    base = done_cnt;
    @(posedge clk);
    #1;
    buttons  = 12'h001;
    send_req = 1'b1;
    @(posedge clk);
    #1;
    buttons = 12'h800;
    wait_done(base + 2, 300, "done_b2b_2");
    #1;
    send_req = 1'b0;
    wait_done(base + 3, 200, "done_b2b_3");
    if (done_cycles.size() >= base + 3) begin
      check("b2b_period_1", done_cycles[base+1] - done_cycles[base], 32'd105);
      check("b2b_period_2", done_cycles[base+2] - done_cycles[base+1], 32'd105);
    end else begin
      check("b2b_done_count", done_cycles.size(), base + 3);
    end

    // reset at bit 5 aborts the frame without a latch pulse
    saved_word    = rx_word;
    saved_latches = latch_pulses;
    base          = done_cnt;
    start_frame(12'h3C3);
    wait_edges(7, 100, "reach_bit5");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {27'd0, busy, done, pmod_data, pmod_clk, pmod_latch}, 32'd0);
    repeat (120) @(posedge clk);
    check("abort_no_latch", latch_pulses, saved_latches);
    check("abort_word_kept", {20'd0, rx_word}, {20'd0, saved_word});
    check("abort_no_done", done_cnt, base);

    exp_q.push_back('{word: 12'h0F0, present: 1'b1});
    start_frame(12'h0F0);
    wait_done(base + 1, 200, "done_after_abort");

    // all-ones decodes as not present, all-zeros as present with nothing pressed
    exp_q.push_back('{word: 12'hFFF, present: 1'b0});
    start_frame(12'hFFF);
    wait_done(base + 2, 200, "done_fff");
    exp_q.push_back('{word: 12'h000, present: 1'b1});
    start_frame(12'h000);
    wait_done(base + 3, 200, "done_000");

    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
